// File: rtl/memory_stage.sv
// memory_stage -- LEGv8 memory stage with the EX/MEM pipeline register.
//
// Captures the execute-stage results every cycle the stage is not stalled,
// resolves CBZ (PCSrc_M) and runs LDUR/STUR data-memory accesses over a
// req/ack handshake. While an access is outstanding the stage asserts
// stall_M so that everything upstream holds.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   valid_E, flush_E    execute-stage instruction valid / discard request
//   Branch_E, MemRead_E, MemWrite_E, zero_E   control and ALU flag
//   PCBranch_E, aluResult_E, writeData_E      execute-stage datapath values
//   dm_req, dm_we, dm_addr, dm_wdata          data-memory request side
//   dm_rdata, dm_ack                          data-memory response side
//   stall_M             hold execute stage and upstream
//   valid_M, PCSrc_M, PCBranch_M, aluResult_M, readData_M   stage outputs
//   err_M               01 misaligned, 10 bus timeout, 00 ok
module memory_stage #(
  parameter int N       = 64,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_E,
  input  logic         flush_E,
  input  logic         Branch_E,
  input  logic         MemRead_E,
  input  logic         MemWrite_E,
  input  logic [N-1:0] PCBranch_E,
  input  logic [N-1:0] aluResult_E,
  input  logic [N-1:0] writeData_E,
  input  logic         zero_E,
  output logic         dm_req,
  output logic         dm_we,
  output logic [N-1:0] dm_addr,
  output logic [N-1:0] dm_wdata,
  input  logic [N-1:0] dm_rdata,
  input  logic         dm_ack,
  output logic         stall_M,
  output logic         valid_M,
  output logic         PCSrc_M,
  output logic [N-1:0] PCBranch_M,
  output logic [N-1:0] aluResult_M,
  output logic [N-1:0] readData_M,
  output logic [1:0]   err_M
);

  // The counter only needs to reach TIMEOUT-1: the exit decision is taken
  // on the edge that ends the TIMEOUT-th BUS cycle.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic          valid_cap;
  logic          branch;
  logic          zero;
  logic          mem_read;
  logic          mem_write;
  logic [N-1:0]  write_data;
  logic [CW-1:0] cnt;

  logic capture;
  logic mem_op_e;
  logic aligned_e;
  logic timeout_hit;
  logic read_op;

  assign capture   = (state != BUS);
  assign mem_op_e  = valid_E & ~flush_E & (MemRead_E | MemWrite_E);
  assign aligned_e = (aluResult_E[2:0] == 3'b000);
  // Read+write together is treated as a write, so only a pure read loads data.
  assign read_op   = mem_read & ~mem_write;
  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: state_next = (mem_op_e && aligned_e) ? BUS : IDLE;
      BUS:        if (dm_ack || timeout_hit) state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  always_comb begin
    dm_req   = (state == BUS);
    dm_we    = dm_req & mem_write;
    dm_addr  = dm_req ? aluResult_M : '0;
    dm_wdata = dm_req ? write_data : '0;
    stall_M  = dm_req;
    valid_M  = valid_cap & (state != BUS);
    PCSrc_M  = valid_M & branch & zero;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      valid_cap   <= 1'b0;
      branch      <= 1'b0;
      zero        <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      write_data  <= '0;
      PCBranch_M  <= '0;
      aluResult_M <= '0;
      readData_M  <= '0;
      err_M       <= 2'b00;
      cnt         <= '0;
    end else begin
      state <= state_next;
      if (capture) begin
        valid_cap   <= valid_E & ~flush_E;
        branch      <= Branch_E;
        zero        <= zero_E;
        mem_read    <= MemRead_E;
        mem_write   <= MemWrite_E;
        write_data  <= writeData_E;
        PCBranch_M  <= PCBranch_E;
        aluResult_M <= aluResult_E;
        // A misaligned access never reaches the bus; it just reports here.
        err_M       <= (mem_op_e && !aligned_e) ? 2'b01 : 2'b00;
        cnt         <= '0;
      end else if (dm_ack) begin
        // Ack beats a coincident timeout.
        cnt <= '0;
        if (read_op) readData_M <= dm_rdata;
      end else if (timeout_hit) begin
        cnt        <= '0;
        err_M      <= 2'b10;
        readData_M <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage -- scoreboard bench for memory_stage (TIMEOUT = 4).
//
// Each issued instruction pushes its expected outputs; the monitor pops and
// compares them whenever valid_M is seen. A small memory responder inside
// the issue task acks after a chosen number of BUS cycles (0 = never).
module tb_memory_stage;

  localparam int N  = 64;
  localparam int TO = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         valid_E = 1'b0, flush_E = 1'b0, Branch_E = 1'b0;
  logic         MemRead_E = 1'b0, MemWrite_E = 1'b0, zero_E = 1'b0;
  logic [N-1:0] PCBranch_E = '0, aluResult_E = '0, writeData_E = '0;
  logic         dm_req, dm_we;
  logic [N-1:0] dm_addr, dm_wdata;
  logic [N-1:0] dm_rdata = '0;
  logic         dm_ack = 1'b0;
  logic         stall_M, valid_M, PCSrc_M;
  logic [N-1:0] PCBranch_M, aluResult_M, readData_M;
  logic [1:0]   err_M;

  memory_stage #(.N(N), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .valid_E(valid_E), .flush_E(flush_E), .Branch_E(Branch_E),
    .MemRead_E(MemRead_E), .MemWrite_E(MemWrite_E),
    .PCBranch_E(PCBranch_E), .aluResult_E(aluResult_E),
    .writeData_E(writeData_E), .zero_E(zero_E),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .stall_M(stall_M), .valid_M(valid_M), .PCSrc_M(PCSrc_M),
    .PCBranch_M(PCBranch_M), .aluResult_M(aluResult_M),
    .readData_M(readData_M), .err_M(err_M)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [63:0] alu;
    logic [63:0] pcb;
    logic [63:0] rdata;
    logic        pcsrc;
    logic [1:0]  err;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] rd_model = '0;
  logic        bus_exp = 1'b0;

  // Monitor: dm_req must match the expected bus phase; each valid_M pops one entry.
  always @(negedge clk) begin
    exp_t e;
    check("dm_req_phase", {63'd0, dm_req}, {63'd0, bus_exp});
    if (valid_M === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", {63'd0, valid_M}, 64'd0);
      end else begin
        e = sb.pop_front();
        check("out_alu", aluResult_M, e.alu);
        check("out_pcb", PCBranch_M, e.pcb);
        check("out_pcsrc", {63'd0, PCSrc_M}, {63'd0, e.pcsrc});
        check("out_rdata", readData_M, e.rdata);
        check("out_err", {62'd0, err_M}, {62'd0, e.err});
        $display("[TB] out alu=%0h pcb=%0h pcsrc=%0b rdata=%0h err=%0b",
                 aluResult_M, PCBranch_M, PCSrc_M, readData_M, err_M);
      end
    end
  end

  task automatic idle_inputs();
    valid_E = 1'b0; flush_E = 1'b0; Branch_E = 1'b0; zero_E = 1'b0;
    MemRead_E = 1'b0; MemWrite_E = 1'b0;
    PCBranch_E = '0; aluResult_E = '0; writeData_E = '0;
  endtask

  task automatic issue(input logic v, input logic fl, input logic br, input logic z,
                       input logic mr, input logic mw,
                       input logic [63:0] pcb, input logic [63:0] alu,
                       input logic [63:0] wd, input int ack_at,
                       input logic [63:0] rdata);
    exp_t e;
    logic memop, bus;
    int   n, exp_n;
    valid_E = v; flush_E = fl; Branch_E = br; zero_E = z;
    MemRead_E = mr; MemWrite_E = mw;
    PCBranch_E = pcb; aluResult_E = alu; writeData_E = wd;
    @(posedge clk); #1;
    idle_inputs();
    memop   = v & ~fl & (mr | mw);
    bus     = memop && (alu[2:0] == 3'b000);
    e.alu   = alu;
    e.pcb   = pcb;
    e.pcsrc = br & z;
    e.err   = (memop && !bus) ? 2'b01 : 2'b00;
    if (bus) begin
      bus_exp = 1'b1;
      check("stall_after_capture", {63'd0, stall_M}, 64'd1);
      n = 0;
      while (stall_M === 1'b1 && n < 20) begin
        n++;
        check("bus_addr", dm_addr, alu);
        check("bus_we", {63'd0, dm_we}, {63'd0, mw});
        check("bus_valid_low", {63'd0, valid_M}, 64'd0);
        if (mw) check("bus_wdata", dm_wdata, wd);
        if (n == ack_at) begin
          dm_ack = 1'b1;
          dm_rdata = rdata;
        end
        @(posedge clk); #1;
        dm_ack = 1'b0;
        dm_rdata = '0;
      end
      bus_exp = 1'b0;
      exp_n = (ack_at > 0 && ack_at <= TO) ? ack_at : TO;
      check("bus_cycles", n, exp_n);
      if (ack_at > 0 && ack_at <= TO) begin
        if (mr && !mw) rd_model = rdata;
      end else begin
        e.err = 2'b10;
        rd_model = '0;
      end
    end else begin
      check("no_stall", {63'd0, stall_M}, 64'd0);
    end
    e.rdata = rd_model;
    if (v && !fl) begin
      sb.push_back(e);
    end else begin
      check("dropped_valid", {63'd0, valid_M}, 64'd0);
      check("dropped_pcsrc", {63'd0, PCSrc_M}, 64'd0);
    end
    $display("[TB] issue v=%0b fl=%0b br=%0b z=%0b mr=%0b mw=%0b alu=%0h ack_at=%0d",
             v, fl, br, z, mr, mw, alu, ack_at);
  endtask

  initial begin
    #12;
    check("rst_valid", {63'd0, valid_M}, 64'd0);
    check("rst_stall", {63'd0, stall_M}, 64'd0);
    check("rst_alu", aluResult_M, 64'd0);
    check("rst_err", {62'd0, err_M}, 64'd0);
    @(negedge clk); reset = 1'b1;

    //     v  fl br z  mr mw  pcb       alu       wd        ack  rdata
    issue(1, 0, 0, 0, 0, 0, 64'h0,   64'h2A, 64'h0,  0, 64'h0);
    issue(1, 0, 1, 1, 0, 0, 64'h100, 64'h0,  64'h0,  0, 64'h0);
    issue(1, 0, 1, 0, 0, 0, 64'h100, 64'h0,  64'h0,  0, 64'h0);
    issue(1, 1, 1, 1, 0, 0, 64'h100, 64'h0,  64'h0,  0, 64'h0);
    issue(1, 0, 0, 0, 1, 0, 64'h0,   64'h40, 64'h0,  3, 64'hDEADBEEF);
    issue(1, 0, 0, 0, 0, 0, 64'h4,   64'h77, 64'h0,  0, 64'h0);
    issue(1, 0, 0, 0, 0, 1, 64'h0,   64'h8,  64'h55, 1, 64'h0);
    issue(1, 0, 0, 0, 0, 1, 64'h0,   64'h9,  64'h66, 0, 64'h0);
    issue(1, 0, 0, 0, 1, 0, 64'h0,   64'h10, 64'h0,  0, 64'h0);
    issue(1, 0, 0, 0, 1, 0, 64'h0,   64'h18, 64'h0,  4, 64'h1234);
    issue(1, 0, 1, 1, 0, 1, 64'h200, 64'h20, 64'hAB, 2, 64'h0);
    issue(1, 0, 0, 0, 1, 1, 64'h0,   64'h28, 64'hCD, 1, 64'hBAD);
    issue(1, 0, 0, 0, 1, 0, 64'h0,   64'h33, 64'h0,  0, 64'h0);
    issue(0, 0, 1, 1, 0, 0, 64'h300, 64'h5,  64'h0,  0, 64'h0);

    // Reset in the middle of a bus access.
    valid_E = 1'b1; MemRead_E = 1'b1; aluResult_E = 64'h80;
    @(posedge clk); #1;
    idle_inputs();
    bus_exp = 1'b1;
    @(posedge clk); #1;
    check("midrst_req_before", {63'd0, dm_req}, 64'd1);
    bus_exp = 1'b0;
    reset = 1'b0;
    #1;
    check("midrst_req", {63'd0, dm_req}, 64'd0);
    check("midrst_stall", {63'd0, stall_M}, 64'd0);
    check("midrst_alu", aluResult_M, 64'd0);
    check("midrst_rdata", readData_M, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    rd_model = '0;
    @(posedge clk); #1;
    check("post_rst_valid", {63'd0, valid_M}, 64'd0);
    check("post_rst_stall", {63'd0, stall_M}, 64'd0);
    check("post_rst_err", {62'd0, err_M}, 64'd0);
    check("post_rst_rdata", readData_M, 64'd0);

    issue(1, 0, 0, 0, 0, 0, 64'h8, 64'h99, 64'h0, 0, 64'h0);
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Memory stage of the 64-bit LEGv8 datapath. Sits directly downstream of the execute stage.
- Contains the EX/MEM pipeline register, which captures execute-stage results.
- Resolves CBZ branches and runs LDUR/STUR accesses to data memory over a req/ack handshake.
- Stalls upstream while an access is outstanding, and flags misaligned or timed-out accesses.

Parameters:
- N, 64, datapath width.
- TIMEOUT, 16, max cycles dm_req may wait for dm_ack before a bus error; 0 disables the timeout.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- valid_E  in  1  execute stage holds a real instruction
- flush_E  in  1  discard the instruction being captured
- Branch_E  in  1  CBZ control
- MemRead_E  in  1  load control
- MemWrite_E  in  1  store control
- PCBranch_E  in  N  branch target
- aluResult_E  in  N  ALU result / memory address
- writeData_E  in  N  store data
- zero_E  in  1  ALU zero flag
- dm_req  out  1  memory request
- dm_we  out  1  1 = write
- dm_addr  out  N  byte address
- dm_wdata  out  N  store data
- dm_rdata  in  N  load data
- dm_ack  in  1  access complete
- stall_M  out  1  hold execute stage and upstream
- valid_M  out  1  M outputs valid this cycle
- PCSrc_M  out  1  take branch
- PCBranch_M  out  N  registered branch target
- aluResult_M  out  N  registered ALU result
- readData_M  out  N  load data
- err_M  out  2  01 misaligned, 10 bus timeout, 00 ok

Behaviour:
Reset:
- All registers, all outputs and the timeout counter are 0 while reset=0, asynchronously.
- State returns to IDLE.
- Any in-flight access is abandoned; dm_req drops immediately.

Capture (each rising edge with stall_M=0):
- EX/MEM registers load all *_E inputs.
- Captured valid bit = valid_E & ~flush_E.
- When stall_M=1, EX/MEM registers and the valid bit hold; flush_E is ignored.
- A memory op is captured valid & (MemRead|MemWrite).
- Aligned means aluResult_E[2:0]==0.
- If both MemRead and MemWrite are set, treat the op as a write.

FSM states: IDLE, BUS, DONE.
- IDLE → BUS on a capture edge with an aligned memory op.
- IDLE otherwise stays IDLE. A misaligned memory op sets err_M=01, issues no request and completes like a non-memory op.
- BUS: dm_req=1, dm_we=MemWrite_M, dm_addr=aluResult_M, dm_wdata=writeData_M, stall_M=1. The timeout counter increments each cycle.
- BUS → DONE on the edge where dm_ack=1. On a read, readData_M is loaded with dm_rdata.
- BUS → DONE with err_M=10 and readData_M=0 when the counter reaches TIMEOUT without ack.
- If ack and timeout occur on the same edge, ack wins.
- DONE: stall_M=0. Next edge: capture as from IDLE (DONE → BUS or IDLE). The counter clears on every transition out of BUS.
- dm_ack outside BUS is ignored. dm_req, dm_we, dm_addr and dm_wdata are 0 outside BUS.

Outputs:
- valid_M = captured valid & (state != BUS).
- PCSrc_M = valid_M & Branch_M & zero_M.
- err_M is cleared at the next capture edge.
- readData_M holds until the next read completes.

Latency:
- Non-memory op or misaligned op: outputs 1 cycle after capture.
- Memory op: 1 + (cycles until ack) + 1.
- stall_M is asserted starting in the cycle after capture.

Branch/memory: a store with Branch=1 is legal; both take effect.

Test Plan:
1. Reset mid-access: reset=0 during BUS → dm_req=0 and stall_M=0 immediately; state IDLE; all outputs 0 after release.
2. ALU op: valid_E=1, aluResult_E=0x2A, no mem ctrl → next cycle valid_M=1, aluResult_M=0x2A, stall_M=0, dm_req never asserts.
3. CBZ: Branch_E=1, zero_E=1, PCBranch_E=0x100 → next cycle PCSrc_M=1, PCBranch_M=0x100. Same with zero_E=0 → PCSrc_M=0. With flush_E=1 → valid_M=0, PCSrc_M=0.
4. Load, ack after 3 cycles: MemRead_E=1, addr 0x40 → dm_req=1 and dm_addr=0x40 for 3 cycles, stall_M=1 throughout. dm_ack=1 with dm_rdata=0xDEADBEEF → next cycle valid_M=1, readData_M=0xDEADBEEF, stall_M=0. The following instruction is captured on the DONE edge.
5. Store: MemWrite_E=1, addr 0x8, data 0x55, ack after 1 cycle → dm_we=1, dm_wdata=0x55 for one cycle; err_M=00. Misaligned store at 0x9 → dm_req stays 0; next cycle valid_M=1, err_M=01.
6. Timeout: TIMEOUT=4, load with dm_ack held 0 → dm_req high for 4 cycles, then err_M=10, readData_M=0, stall_M=0. A variant with ack arriving on the 4th cycle → err_M=00 and data is loaded.
